// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic definitions for the NTT butterfly datapath.
//   coeff_t      : signed 16-bit coefficient
//   bfly_mode_e  : butterfly flavour carried with each token
//   KYBER_Q, QINV, BARRETT_V, MONT_R and pre-widened copies used by the multipliers
package kyber_pkg;

  typedef logic signed [15:0] coeff_t;

  typedef enum logic {
    ModeFwd = 1'b0,  // Cooley-Tukey
    ModeInv = 1'b1   // Gentleman-Sande
  } bfly_mode_e;

  localparam int KYBER_Q   = 3329;
  localparam int QINV      = -3327;  // q^-1 mod 2^16, signed
  localparam int BARRETT_V = 20159;  // round(2^26 / q)
  localparam int MONT_R    = 2285;   // 2^16 mod q

  // Operand forms sized for the 32-bit datapath.
  localparam logic signed [31:0] Q32         = 32'(KYBER_Q);
  localparam logic signed [31:0] BARRETT_V32 = 32'(BARRETT_V);
  localparam logic signed [31:0] BARRETT_RND = 32'sd33554432;  // 2^25
  localparam logic [15:0]        QINV_LO     = 16'(QINV);      // 0xF301

endpackage

// File: rtl/mont_reduce_pipe.sv
// Three-stage Montgomery reduction: r = p * 2^-16 mod q, |r| < q for in-range p.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : pipeline advance; all stages hold when low
//   p          : 32-bit signed product entering the reduction
//   r          : reduced coefficient, valid three enabled cycles after p
module mont_reduce_pipe
  import kyber_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [31:0] p,
  output coeff_t             r
);

  coeff_t             u_d, u_q;
  logic signed [31:0] p2_q;
  logic signed [31:0] m_d, m_q;
  logic signed [31:0] p3_q;
  coeff_t             r_d, r_q;

  always_comb begin
    // Only the low 16 bits of the product matter; the result is reinterpreted as signed.
    u_d = coeff_t'(p[15:0] * QINV_LO);
    m_d = 32'(u_q) * Q32;
    // Low half of p - m is zero by construction, so the high half is the exact quotient.
    r_d = coeff_t'((p3_q - m_q) >>> 16);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q  <= '0;
      p2_q <= '0;
      m_q  <= '0;
      p3_q <= '0;
      r_q  <= '0;
    end else if (en) begin
      u_q  <= u_d;
      p2_q <= p;
      m_q  <= m_d;
      p3_q <= p2_q;
      r_q  <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined Kyber NTT/INTT butterfly, one coefficient pair per cycle, 5-cycle latency.
//   mode 0 (forward CT): t = fqmul(zeta, b); a_out = a + t;        b_out = a - t
//   mode 1 (inverse GS): a_out = barrett(a + b); b_out = fqmul(zeta, b - a)
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready is combinational)
//   mode, a, b, zeta     : token payload, zeta in Montgomery domain
//   tag_in / tag_out     : opaque sideband carried unchanged
//   out_valid / out_ready: output handshake
//   a_out, b_out         : butterfly results
// Flow control is a global stall: every stage advances together when the output slot
// is empty or being consumed, so order is preserved and nothing is dropped.
module ntt_butterfly
  import kyber_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  input  logic signed [15:0] zeta,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] a_out,
  output logic signed [15:0] b_out,
  output logic [TAG_W-1:0]   tag_out
);

  logic adv;

  // Stage 1: twiddle product and x lane
  logic               v1_q;
  bfly_mode_e         mode1_q;
  logic [TAG_W-1:0]   tag1_q;
  coeff_t             x1_d, x1_q;
  coeff_t             mul_op;
  logic signed [31:0] p1_d, p1_q;

  // Stage 2..4: Montgomery reduction in mont_reduce_pipe, Barrett on x alongside
  logic               v2_q, v3_q, v4_q;
  bfly_mode_e         mode2_q, mode3_q, mode4_q;
  logic [TAG_W-1:0]   tag2_q, tag3_q, tag4_q;
  coeff_t             x2_q, x3_q, x4_q;
  logic signed [31:0] bprod_d, bprod_q;
  coeff_t             k_d, k_q;
  coeff_t             y_d, y4_q;
  coeff_t             r4;

  // Stage 5: output register
  logic               v5_q;
  logic [TAG_W-1:0]   tag5_q;
  coeff_t             a5_d, a5_q;
  coeff_t             b5_d, b5_q;

  assign adv      = !v5_q || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // S1: one shared multiplier, operand chosen by mode.
  always_comb begin
    mul_op = b;
    x1_d   = a;
    if (mode) begin
      mul_op = b - a;
      x1_d   = a + b;
    end
    p1_d = 32'(zeta) * 32'(mul_op);
  end

  // ---------------------------------------------------------------------------
  // Barrett lane: k = (v*x + 2^25) >>> 26 spread over S2/S3, y = x - k*q in S4.
  always_comb begin
    bprod_d = 32'(x1_q) * BARRETT_V32;
    k_d     = coeff_t'((bprod_q + BARRETT_RND) >>> 26);
    y_d     = coeff_t'(32'(x3_q) - 32'(k_q) * Q32);
  end

  mont_reduce_pipe u_mont (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .p     (p1_q),
    .r     (r4)
  );

  // ---------------------------------------------------------------------------
  // S5: final add/sub or select, 16-bit two's-complement wrap.
  always_comb begin
    a5_d = x4_q + r4;
    b5_d = x4_q - r4;
    unique case (mode4_q)
      ModeFwd: begin
        a5_d = x4_q + r4;
        b5_d = x4_q - r4;
      end
      ModeInv: begin
        a5_d = y4_q;
        b5_d = r4;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Bubbles shift through as valid = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      mode1_q <= ModeFwd;
      tag1_q  <= '0;
      x1_q    <= '0;
      p1_q    <= '0;
      v2_q    <= 1'b0;
      mode2_q <= ModeFwd;
      tag2_q  <= '0;
      x2_q    <= '0;
      bprod_q <= '0;
      v3_q    <= 1'b0;
      mode3_q <= ModeFwd;
      tag3_q  <= '0;
      x3_q    <= '0;
      k_q     <= '0;
      v4_q    <= 1'b0;
      mode4_q <= ModeFwd;
      tag4_q  <= '0;
      x4_q    <= '0;
      y4_q    <= '0;
      v5_q    <= 1'b0;
      tag5_q  <= '0;
      a5_q    <= '0;
      b5_q    <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      mode1_q <= bfly_mode_e'(mode);
      tag1_q  <= tag_in;
      x1_q    <= x1_d;
      p1_q    <= p1_d;

      v2_q    <= v1_q;
      mode2_q <= mode1_q;
      tag2_q  <= tag1_q;
      x2_q    <= x1_q;
      bprod_q <= bprod_d;

      v3_q    <= v2_q;
      mode3_q <= mode2_q;
      tag3_q  <= tag2_q;
      x3_q    <= x2_q;
      k_q     <= k_d;

      v4_q    <= v3_q;
      mode4_q <= mode3_q;
      tag4_q  <= tag3_q;
      x4_q    <= x3_q;
      y4_q    <= y_d;

      v5_q    <= v4_q;
      tag5_q  <= tag4_q;
      a5_q    <= a5_d;
      b5_q    <= b5_d;
    end
  end

  assign out_valid = v5_q;
  assign a_out     = a5_q;
  assign b_out     = b5_q;
  assign tag_out   = tag5_q;

endmodule
